// File: rtl/thread_pc_sched.sv
// Round-robin barrel-thread scheduler and owner of the per-thread PC memory write port.
// It walks the PC memory to STARTUP_ADDR after reset. It then issues one thread per
// cycle, commits execute-stage next-PCs, and applies host halt/resume requests.
module thread_pc_sched #(
   parameter int unsigned            NUM_THREADS  = 16,
   parameter int unsigned            EXE_STAGE    = 7,
   parameter int unsigned            DWIDTH       = 32,
   parameter int unsigned            PC_WIDTH     = 12,
   parameter logic [PC_WIDTH-1:0]    STARTUP_ADDR = '0,
   parameter logic [NUM_THREADS-1:0] ACTIVE_RESET = '1,
   localparam int unsigned           TW           = $clog2(NUM_THREADS)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [DWIDTH-1:0]      i_pc_next,
   input  logic                   i_halt_valid,
   input  logic [TW-1:0]          i_halt_tid,
   input  logic                   i_resume_valid,
   input  logic [TW-1:0]          i_resume_tid,
   input  logic [PC_WIDTH-1:0]    i_resume_pc,
   output logic                   o_resume_ready,
   output logic [TW-1:0]          o_thread_index_fetch,
   output logic                   o_fetch_valid,
   output logic [TW-1:0]          o_thread_index_execute,
   output logic                   o_execute_valid,
   output logic                   o_pc_we,
   output logic [TW-1:0]          o_pc_waddr,
   output logic [PC_WIDTH-1:0]    o_pc_wdata,
   output logic                   o_init_done,
   output logic [NUM_THREADS-1:0] o_active_mask
);

   typedef enum logic {S_INIT, S_RUN} state_t;

   state_t                           state_q, state_d;
   logic [TW-1:0]                    init_cnt_q, init_cnt_d;
   logic                             pend_q, pend_d;
   logic [TW-1:0]                    pend_tid_q, pend_tid_d;
   logic [PC_WIDTH-1:0]              pend_pc_q, pend_pc_d;
   logic [EXE_STAGE-1:0]             pipe_vld;
   logic [EXE_STAGE-1:0][TW-1:0]     pipe_tid;

   logic                             pc_we_d;
   logic [TW-1:0]                    pc_waddr_d;
   logic [PC_WIDTH-1:0]              pc_wdata_d;
   logic                             done_d;
   logic [NUM_THREADS-1:0]           act_d;
   logic [TW-1:0]                    fetch_idx_d;
   logic                             fetch_vld_d;
   logic                             ready_d;

   logic                             halt_acc;
   logic                             res_acc;
   logic                             halt_hits_pend;
   logic                             apply_resume;
   logic                             unused_pc_hi;

   // Only the low PC_WIDTH bits of the next PC are stored.
   assign unused_pc_hi = ^i_pc_next[DWIDTH-1:PC_WIDTH];

   // Host requests only take effect once the scheduler is running.
   assign halt_acc       = o_init_done & i_halt_valid;
   assign res_acc        = o_resume_ready & i_resume_valid;
   assign halt_hits_pend = halt_acc & pend_q & (i_halt_tid == pend_tid_q);
   // A pending resume lands in a dead execute slot of its own thread. That slot cannot
   // collide with a writeback.
   assign apply_resume   = o_init_done & pend_q & ~o_execute_valid &
                           (o_thread_index_execute == pend_tid_q) & ~halt_hits_pend;

   assign o_thread_index_execute = pipe_tid[EXE_STAGE-1];
   assign o_execute_valid        = pipe_vld[EXE_STAGE-1];

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_INIT;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: INIT ends after the last PC address has been written.
   always_comb begin
      state_d = state_q;
      if ((state_q == S_INIT) && (init_cnt_q == TW'(NUM_THREADS - 1))) begin
         state_d = S_RUN;
      end
   end

   // Next values of every registered output and of the bookkeeping state.
   always_comb begin
      init_cnt_d  = init_cnt_q;
      pc_we_d     = 1'b0;
      pc_waddr_d  = '0;
      pc_wdata_d  = '0;
      done_d      = 1'b0;
      act_d       = o_active_mask;
      pend_d      = pend_q;
      pend_tid_d  = pend_tid_q;
      pend_pc_d   = pend_pc_q;
      fetch_idx_d = '0;
      fetch_vld_d = 1'b0;
      ready_d     = 1'b0;
      case (state_q)
         S_INIT: begin
            init_cnt_d = init_cnt_q + TW'(1);
            pc_we_d    = 1'b1;
            pc_waddr_d = init_cnt_q;
            pc_wdata_d = STARTUP_ADDR;
         end
         S_RUN: begin
            done_d = 1'b1;
            if (!o_init_done) begin
               act_d = ACTIVE_RESET;
            end else begin
               if (o_execute_valid) begin
                  pc_we_d    = 1'b1;
                  pc_waddr_d = o_thread_index_execute;
                  pc_wdata_d = i_pc_next[PC_WIDTH-1:0];
               end else if (apply_resume) begin
                  pc_we_d             = 1'b1;
                  pc_waddr_d          = pend_tid_q;
                  pc_wdata_d          = pend_pc_q;
                  act_d[pend_tid_q]   = 1'b1;
               end
               if (halt_hits_pend || apply_resume) begin
                  pend_d = 1'b0;
               end
               // A resume of a live thread, or of one halted in the same cycle, is dropped.
               if (res_acc && !(halt_acc && (i_halt_tid == i_resume_tid)) &&
                   !o_active_mask[i_resume_tid]) begin
                  pend_d     = 1'b1;
                  pend_tid_d = i_resume_tid;
                  pend_pc_d  = i_resume_pc;
               end
               if (halt_acc) begin
                  act_d[i_halt_tid] = 1'b0;
               end
               fetch_idx_d = o_thread_index_fetch + TW'(1);
            end
            fetch_vld_d = act_d[fetch_idx_d];
            ready_d     = ~pend_d;
         end
         default: ;
      endcase
   end

   // Output, bookkeeping and execute-pipe registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         init_cnt_q           <= '0;
         pend_q               <= 1'b0;
         pend_tid_q           <= '0;
         pend_pc_q            <= '0;
         o_pc_we              <= 1'b0;
         o_pc_waddr           <= '0;
         o_pc_wdata           <= '0;
         o_init_done          <= 1'b0;
         o_active_mask        <= '0;
         o_thread_index_fetch <= '0;
         o_fetch_valid        <= 1'b0;
         o_resume_ready       <= 1'b0;
         pipe_vld             <= '0;
         pipe_tid             <= '0;
      end else begin
         init_cnt_q           <= init_cnt_d;
         pend_q               <= pend_d;
         pend_tid_q           <= pend_tid_d;
         pend_pc_q            <= pend_pc_d;
         o_pc_we              <= pc_we_d;
         o_pc_waddr           <= pc_waddr_d;
         o_pc_wdata           <= pc_wdata_d;
         o_init_done          <= done_d;
         o_active_mask        <= act_d;
         o_thread_index_fetch <= fetch_idx_d;
         o_fetch_valid        <= fetch_vld_d;
         o_resume_ready       <= ready_d;
         pipe_vld[0]          <= o_fetch_valid;
         pipe_tid[0]          <= o_thread_index_fetch;
         for (int i = 1; i < int'(EXE_STAGE); i++) begin
            pipe_vld[i] <= pipe_vld[i-1];
            pipe_tid[i] <= pipe_tid[i-1];
         end
      end
   end

endmodule

// File: tb/tb_thread_pc_sched.sv
// Scoreboard bench for thread_pc_sched against a cycle-indexed reference model.
module tb_thread_pc_sched;

   localparam int N    = 16;
   localparam int E    = 7;
   localparam int DW   = 32;
   localparam int PW   = 12;
   localparam int TW   = 4;
   localparam int MAXC = 4096;
   localparam int NCYC = 1500;

   typedef struct {
      int            cyc;
      logic [TW-1:0] addr;
      logic [PW-1:0] data;
   } wr_t;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [DW-1:0] i_pc_next = '0;
   logic          i_halt_valid = 1'b0;
   logic [TW-1:0] i_halt_tid = '0;
   logic          i_resume_valid = 1'b0;
   logic [TW-1:0] i_resume_tid = '0;
   logic [PW-1:0] i_resume_pc = '0;
   logic          o_resume_ready;
   logic [TW-1:0] o_thread_index_fetch;
   logic          o_fetch_valid;
   logic [TW-1:0] o_thread_index_execute;
   logic          o_execute_valid;
   logic          o_pc_we;
   logic [TW-1:0] o_pc_waddr;
   logic [PW-1:0] o_pc_wdata;
   logic          o_init_done;
   logic [N-1:0]  o_active_mask;

   thread_pc_sched dut (
      .clk                    (clk),
      .reset                  (reset),
      .i_pc_next              (i_pc_next),
      .i_halt_valid           (i_halt_valid),
      .i_halt_tid             (i_halt_tid),
      .i_resume_valid         (i_resume_valid),
      .i_resume_tid           (i_resume_tid),
      .i_resume_pc            (i_resume_pc),
      .o_resume_ready         (o_resume_ready),
      .o_thread_index_fetch   (o_thread_index_fetch),
      .o_fetch_valid          (o_fetch_valid),
      .o_thread_index_execute (o_thread_index_execute),
      .o_execute_valid        (o_execute_valid),
      .o_pc_we                (o_pc_we),
      .o_pc_waddr             (o_pc_waddr),
      .o_pc_wdata             (o_pc_wdata),
      .o_init_done            (o_init_done),
      .o_active_mask          (o_active_mask)
   );

   always #5 clk = ~clk;

   int           checks = 0;
   int           errors = 0;
   bit           model_on = 1'b0;
   int           cyc = 0;
   int           mon_cyc = 0;
   wr_t          exp_q[$];
   logic [N-1:0] am;
   bit           pend;
   int           ptid;
   logic [PW-1:0] ppc;
   bit           fvh [MAXC];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t act=%h exp=%h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      cyc     = 0;
      mon_cyc = 0;
      am      = '0;
      pend    = 1'b0;
      ptid    = 0;
      ppc     = '0;
      exp_q.delete();
      for (int a = 0; a < N; a++) begin
         exp_q.push_back('{a, TW'(a), PW'(12'h000)});
      end
   endtask

   // One cycle of the reference model: threads take turns as c-N mod N once running.
   task automatic model_cycle();
      int  c;
      int  fidx;
      int  eidx;
      bit  done;
      bit  fv;
      bit  ev;
      bit  rdy;
      bit  acc;
      bit  apply;
      c    = cyc;
      done = (c >= N);
      fidx = done ? (c - N) % N : 0;
      fv   = done ? am[fidx] : 1'b0;
      fvh[c] = fv;
      eidx = (c - E >= N) ? (c - E - N) % N : 0;
      ev   = (c - E >= N) ? fvh[c - E] : 1'b0;
      rdy  = done && !pend;
      chk("init_done", 32'(o_init_done), 32'(done));
      chk("fetch_tid", 32'(o_thread_index_fetch), 32'(fidx));
      chk("fetch_valid", 32'(o_fetch_valid), 32'(fv));
      chk("exec_tid", 32'(o_thread_index_execute), 32'(eidx));
      chk("exec_valid", 32'(o_execute_valid), 32'(ev));
      chk("resume_ready", 32'(o_resume_ready), 32'(rdy));
      chk("active_mask", 32'(o_active_mask), 32'(am));
      if (c == N - 1) begin
         am = '1;
      end else if (done) begin
         if (ev) exp_q.push_back('{c + 1, TW'(eidx), i_pc_next[PW-1:0]});
         acc   = i_resume_valid && rdy;
         apply = pend && (eidx == ptid) && !ev;
         if (i_halt_valid && pend && (int'(i_halt_tid) == ptid)) begin
            pend  = 1'b0;
            apply = 1'b0;
         end
         if (apply) begin
            exp_q.push_back('{c + 1, TW'(ptid), ppc});
            am[ptid] = 1'b1;
            pend     = 1'b0;
         end
         if (acc && !(i_halt_valid && (i_halt_tid == i_resume_tid)) && !am[i_resume_tid]) begin
            pend = 1'b1;
            ptid = int'(i_resume_tid);
            ppc  = i_resume_pc;
         end
         if (i_halt_valid) am[i_halt_tid] = 1'b0;
      end
      cyc++;
   endtask

   // Reference model process.
   initial begin
      forever begin
         @(negedge clk);
         if (model_on) model_cycle();
      end
   end

   // Write-port monitor: pops the expected write whenever the DUT writes.
   initial begin
      wr_t e;
      forever begin
         @(negedge clk);
         if (model_on) begin
            if (o_pc_we) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_write", 32'(o_pc_waddr), 32'hFFFF_FFFF);
               end else begin
                  e = exp_q.pop_front();
                  chk("wr_cycle", 32'(mon_cyc), 32'(e.cyc));
                  chk("wr_addr", 32'(o_pc_waddr), 32'(e.addr));
                  chk("wr_data", 32'(o_pc_wdata), 32'(e.data));
               end
            end else if (exp_q.size() != 0 && exp_q[0].cyc <= mon_cyc) begin
               e = exp_q.pop_front();
               chk("missing_write", 32'(o_pc_we), 32'h1);
            end
            mon_cyc++;
         end
      end
   end

   task automatic idle_inputs();
      i_halt_valid   = 1'b0;
      i_resume_valid = 1'b0;
      i_halt_tid     = '0;
      i_resume_tid   = '0;
      i_resume_pc    = '0;
   endtask

   task automatic check_reset_outputs();
      chk("rst_we", 32'(o_pc_we), 32'h0);
      chk("rst_waddr", 32'(o_pc_waddr), 32'h0);
      chk("rst_wdata", 32'(o_pc_wdata), 32'h0);
      chk("rst_done", 32'(o_init_done), 32'h0);
      chk("rst_mask", 32'(o_active_mask), 32'h0);
      chk("rst_fetch", 32'({o_thread_index_fetch, o_fetch_valid}), 32'h0);
      chk("rst_exec", 32'({o_thread_index_execute, o_execute_valid}), 32'h0);
      chk("rst_ready", 32'(o_resume_ready), 32'h0);
   endtask

   // Release reset so that the next rising edge starts cycle 0.
   task automatic release_reset();
      @(negedge clk);
      #1;
      reset = 1'b1;
      model_reset();
      model_on = 1'b1;
   endtask

   initial begin
      idle_inputs();
      i_pc_next = 32'h0000_0ABC;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs();

      // Abort init while address 7 is on the write port.
      release_reset();
      repeat (8) @(negedge clk);
      #1;
      reset    = 1'b0;
      model_on = 1'b0;
      #1;
      check_reset_outputs();
      exp_q.delete();
      repeat (2) @(posedge clk);

      // Full run: directed halt/resume scenarios, then random traffic.
      release_reset();
      for (int k = 0; k < NCYC; k++) begin
         @(posedge clk);
         #1;
         idle_inputs();
         if (k < 200) begin
            i_pc_next = 32'h0000_0ABC;
         end else begin
            i_pc_next = $urandom;
         end
         if (k == 40) begin
            i_halt_valid = 1'b1;
            i_halt_tid   = 4'd5;
         end else if (k == 80) begin
            i_resume_valid = 1'b1;
            i_resume_tid   = 4'd5;
            i_resume_pc    = 12'h100;
         end else if (k == 120) begin
            i_halt_valid = 1'b1;
            i_halt_tid   = 4'd3;
         end else if (k == 150) begin
            i_halt_valid   = 1'b1;
            i_halt_tid     = 4'd3;
            i_resume_valid = 1'b1;
            i_resume_tid   = 4'd3;
            i_resume_pc    = 12'h333;
         end else if (k >= 200) begin
            if ($urandom_range(0, 9) == 0) begin
               i_halt_valid = 1'b1;
               i_halt_tid   = TW'($urandom_range(0, N - 1));
            end
            if ($urandom_range(0, 4) == 0) begin
               i_resume_valid = 1'b1;
               i_resume_tid   = TW'($urandom_range(0, N - 1));
               i_resume_pc    = PW'($urandom);
            end
         end
      end
      @(posedge clk);
      #1;
      idle_inputs();
      repeat (3 * N) @(posedge clk);
      @(negedge clk);
      #1;
      model_on = 1'b0;
      while (exp_q.size() != 0 && exp_q[0].cyc < mon_cyc) begin
         void'(exp_q.pop_front());
         chk("stale_write", 32'h0, 32'h1);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/thread_pc_sched.md
# thread_pc_sched

Round-robin thread scheduler and PC-memory sequencer for the barrel-threaded core. It generates the per-cycle fetch thread index and its execute-stage copy, and owns the single write port of the per-thread PC memory. Through that port it initialises every thread to STARTUP_ADDR, commits execute-stage next-PCs, and applies host halt/resume requests. It sits between the host/debug control interface and the PC register file.

## Interface
- NUM_THREADS, 16: thread count; power of two, ≥ EXE_STAGE+2 (PC write must land before the thread's next fetch)
- EXE_STAGE, 7: cycles from fetch slot to execute slot
- DWIDTH, 32: datapath width
- PC_WIDTH, 12: stored PC bits
- STARTUP_ADDR, 0: reset PC for all threads
- ACTIVE_RESET, all ones: thread-active mask after init; NUM_THREADS bits

Ports (TW = $clog2(NUM_THREADS)):
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset
- i_pc_next  input  DWIDTH  next PC of the thread in the execute slot
- i_halt_valid  input  1  halt request pulse
- i_halt_tid  input  TW  thread to halt
- i_resume_valid  input  1  resume request
- i_resume_tid  input  TW  thread to resume
- i_resume_pc  input  PC_WIDTH  PC to load on resume
- o_resume_ready  output  1  resume accepted when valid&&ready
- o_thread_index_fetch  output  TW  fetch slot thread (PC memory read address)
- o_fetch_valid  output  1  fetch slot thread is active
- o_thread_index_execute  output  TW  execute slot thread
- o_execute_valid  output  1  execute slot carries a live instruction
- o_pc_we  output  1  PC memory write enable
- o_pc_waddr  output  TW  PC memory write address
- o_pc_wdata  output  PC_WIDTH  PC memory write data
- o_init_done  output  1  init finished
- o_active_mask  output  NUM_THREADS  per-thread active bits

## Operation
- FSM states: INIT and RUN. Reset enters INIT. No other transition back to INIT.
- INIT: an init counter walks 0..NUM_THREADS-1. Each cycle: o_pc_we=1, o_pc_waddr=counter, o_pc_wdata=STARTUP_ADDR. After the last address: go to RUN, set o_init_done=1, load the active mask with ACTIVE_RESET. Fetch and execute stay invalid during INIT.
- RUN issue counter: starts at 0 and increments every cycle, wrapping NUM_THREADS-1→0. o_thread_index_fetch = counter. o_fetch_valid = active[counter].
- Execute pipe: (tid, valid) shift register, EXE_STAGE deep, cleared at reset. o_thread_index_execute/o_execute_valid are the fetch pair delayed EXE_STAGE cycles.
- Writeback: when o_execute_valid=1 at cycle c, then at cycle c+1 o_pc_we=1, o_pc_waddr=execute tid, o_pc_wdata=i_pc_next[PC_WIDTH-1:0] as sampled at c. Upper bits are discarded.
- Halt:
  - Accepted any RUN cycle. Clears active[tid] next cycle.
  - An instruction of that thread already in flight completes and writes back normally.
  - Halting an inactive thread: no effect. Ignored in INIT.
- Resume:
  - o_resume_ready=1 in RUN when no resume is pending.
  - Resume of an already-active thread is accepted and dropped.
  - Otherwise the tid and PC are latched as pending.
  - Pending resume is applied in the first cycle where execute tid == pending tid and o_execute_valid=0. Next cycle: o_pc_we=1, waddr=tid, wdata=resume PC, active[tid] set, pending cleared.
  - Worst-case apply latency: 2·NUM_THREADS cycles.
- Halt and resume together:
  - Halt of the pending-resume tid cancels the pending resume.
  - Simultaneous accepted halt and resume of the same tid: halt wins and the resume is discarded.
- Write-port priority: INIT > writeback > resume. Writeback and resume never collide, because resume applies only in an invalid execute slot.

## Timing
- Reset low: all outputs 0, o_active_mask=0, state INIT, pipe cleared. Reset mid-operation aborts immediately; init restarts from address 0.
- First cycle after reset release: init write to address 0. Writes to NUM_THREADS-1 complete in cycle NUM_THREADS-1. o_init_done=1 from cycle NUM_THREADS.
- First valid fetch: cycle NUM_THREADS, tid 0. First o_execute_valid: cycle NUM_THREADS+EXE_STAGE.
- All outputs registered. o_pc_we/addr/data lag the execute slot by 1 cycle.
- Fetch-to-PC-update of the same thread: EXE_STAGE+1 cycles, strictly less than NUM_THREADS.

## Test plan
- Reset release with N=16, STARTUP_ADDR=0x000 -> 16 writes, addr 0..15, data 0x000. o_init_done rises at cycle 16. Fetch tid 0 valid at cycle 16.
- Steady run, i_pc_next=0x00000ABC -> each execute slot tid t produces a write to addr t with 0xABC one cycle later. The fetch index wraps 15→0.
- Halt tid 5 during RUN -> active[5]=0 next cycle. Tid 5's in-flight instruction still writes back. Later tid-5 fetch slots have o_fetch_valid=0.
- Resume tid 5 with PC 0x100 -> ready drops. Write addr 5 data 0x100 occurs one cycle after the first invalid execute slot for tid 5. active[5]=1 and ready=1 again after the write.
- Same-cycle halt and resume of tid 3, tid 3 halted -> resume discarded, tid 3 stays halted, no write to addr 3.
- Reset asserted at init address 7 -> outputs 0 immediately. After release, init restarts at address 0.
